tile_dma_ctrl: RTL and testbench
================================

Name: tile_dma_ctrl

Overview:
- Per-tile controller between the global buffers and the 4x4 weight-stationary-free systolic array stage.
- Fetches four 32-bit A rows and four 32-bit B rows (4 x int8 each) from the global buffers and presents them on the array's local_buffer_A0..3 / B0..3 inputs.
- Raises busy toward the array, waits for its done, captures the four 128-bit C rows, then writes them back to global buffer C.
- Signals tile completion upstream with a done pulse.

Parameters:
ADDR_BITS, 16, global buffer address width
DATA_BITS, 32, A/B row width (4 x int8)
DATAC_BITS, 128, C row width (4 x int32)
TIMEOUT, 64, max cycles waited for sa_done before error

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin one tile; sampled only in IDLE
base_A  in  ADDR_BITS  first A row address, sampled with start
base_B  in  ADDR_BITS  first B row address, sampled with start
base_C  in  ADDR_BITS  first C row address, sampled with start
A_addr  out  ADDR_BITS  global buffer A read address
A_data  in  DATA_BITS  A read data, valid 1 cycle after A_addr
B_addr  out  ADDR_BITS  global buffer B read address
B_data  in  DATA_BITS  B read data, valid 1 cycle after B_addr
C_wen  out  1  global buffer C write enable
C_addr  out  ADDR_BITS  C write address
C_data  out  DATAC_BITS  C write data
sa_busy  out  1  to array busy input
sa_done  in  1  from array done output
sa_A0..sa_A3  out  DATA_BITS each  to array local_buffer_A0..3
sa_B0..sa_B3  out  DATA_BITS each  to array local_buffer_B0..3
sa_C0..sa_C3  in  DATAC_BITS each  from array local_buffer_C0..3
ready  out  1  high in IDLE
done  out  1  one-cycle pulse after last C write
err  out  1  sticky timeout flag, cleared by next accepted start

Behaviour:
- Reset (async, rst_n=0): state IDLE; A_addr, B_addr, C_addr, C_data, all sa_A*/sa_B* = 0; C_wen, sa_busy, done, err = 0; ready = 1.
- IDLE: ready=1. start=1 latches the three bases, clears err, and moves to FETCH.
- FETCH (5 cycles, idx 0..4):
  - For idx<4, drive A_addr=base_A+idx and B_addr=base_B+idx.
  - For idx>=1, capture A_data/B_data into sa_A[idx-1]/sa_B[idx-1].
  - After idx 4, go to RUN.
- sa_A*/sa_B* are registers: stable from FETCH exit until the next tile's FETCH writes them.
- RUN:
  - sa_busy=1 from the first RUN cycle.
  - The array registers its operands in its idle state on the posedge before it sees busy on the negedge, so operands must already be stable on RUN entry. This is satisfied by the FETCH ordering.
  - When sa_done=1 is sampled, capture sa_C0..3 into C row registers, drop sa_busy the same edge, and go to WB. sa_busy must never be high while the array sits idle after done, otherwise it restarts.
- RUN timeout: a cycle counter starts at RUN entry. If it reaches TIMEOUT without sa_done, set err=1, drop sa_busy, and go to DONE with no C writes.
- WB (4 cycles, r=0..3): C_wen=1, C_addr=base_C+r, C_data=C row r; row 0 = {result0..result3}, MSB first. Then go to DONE.
- DONE: done=1 for one cycle, then back to IDLE.
- Address arithmetic is modulo 2^ADDR_BITS: base+3 wraps silently.
- start while not IDLE: ignored, with no queuing.
- sa_done high during FETCH or WB: ignored.
- Latency start -> done: 1 + 5 + RUN cycles + 4 + 1. With the array's ~9-cycle compute, expect about 20 cycles.
- rst_n low mid-tile: immediate return to reset values. No partial C write may occur after rst_n falls.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, RUN, WB, DONE), ROWS=4, and the default widths.
- One sub-module is natural: tile_row_fetch, the 5-cycle address/capture sequencer for one buffer, instanced twice for A and B.
- The C capture/write-back stays inline.

Test Plan:
1. Reset mid-RUN (rst_n low 2 cycles) -> sa_busy=0, ready=1, no C_wen, all sa_A*/sa_B* = 0.
2. A rows 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 at base_A=0x10; B = identity rows at base_B=0x20; base_C=0x40; real array model -> C writes at 0x40..0x43 equal A×I rows sign-extended per element, then done pulse; ready high after.
3. sa_done stub asserted 3 cycles after sa_busy rises -> sa_busy low the same edge sa_done is sampled; exactly 4 C_wen cycles; C_data equals stub sa_C values 0xAAAA..., 0xBBBB..., 0xCCCC..., 0xDDDD....
4. base_A=0xFFFE -> A_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
5. sa_done held low -> err=1 after TIMEOUT=64 RUN cycles, done pulses, zero C_wen; the next start clears err.
6. start pulsed during FETCH and WB -> ignored; exactly one done pulse per accepted start; back-to-back tiles with start held high yield tiles 1 cycle apart from IDLE.

Source files
------------

// File: rtl/tile_dma_ctrl_pkg.sv
// Shared definitions for the tile DMA controller: controller state encoding,
// array geometry and default bus widths.
package tile_dma_ctrl_pkg;

  // Array geometry: four operand rows in, four result rows out.
  localparam int unsigned Rows    = 4;
  localparam int unsigned RowBits = 2;
  // Sequencing index must reach Rows (FETCH runs Rows + 1 cycles).
  localparam int unsigned IdxBits = 3;

  // Default widths.
  localparam int unsigned DefAddrBits  = 16;
  localparam int unsigned DefDataBits  = 32;
  localparam int unsigned DefDataCBits = 128;
  localparam int unsigned DefTimeout   = 64;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRun,
    StWb,
    StDone
  } state_e;

endpackage

// File: rtl/tile_row_fetch.sv
// Address/capture sequencer for one global buffer (A or B).
//
// During FETCH (idx 0..4) it drives addr = base + idx for idx < 4 and captures
// rd_data into row idx-1 for idx >= 1, matching a buffer whose read data
// appears one cycle after the address. Rows are held until the next FETCH.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : latch base (start accepted in IDLE)
//   base       : first row address
//   fetch      : controller is in FETCH
//   idx        : FETCH cycle index, 0..Rows
//   addr       : buffer read address (0 outside the address phase)
//   rd_data    : buffer read data
//   rows       : captured operand rows, rows[0] is the row at base
module tile_row_fetch
  import tile_dma_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DefAddrBits,
  parameter int unsigned DATA_BITS = DefDataBits
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load,
  input  logic [ADDR_BITS-1:0]             base,
  input  logic                             fetch,
  input  logic [IdxBits-1:0]               idx,
  output logic [ADDR_BITS-1:0]             addr,
  input  logic [DATA_BITS-1:0]             rd_data,
  output logic [Rows-1:0][DATA_BITS-1:0]   rows
);

  logic [ADDR_BITS-1:0]           base_q;
  logic [Rows-1:0][DATA_BITS-1:0] rows_q;
  logic                           addr_phase;
  logic                           capture;

  assign addr_phase = fetch && (idx < IdxBits'(Rows));
  assign capture    = fetch && (idx != '0);

  // Sum truncates to ADDR_BITS, so base + idx wraps modulo the address space.
  assign addr = addr_phase ? (base_q + ADDR_BITS'(idx)) : '0;
  assign rows = rows_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      rows_q <= '0;
    end else begin
      if (load) begin
        base_q <= base;
      end
      if (capture) begin
        rows_q[RowBits'(idx - 1'b1)] <= rd_data;
      end
    end
  end

endmodule

// File: rtl/tile_dma_ctrl.sv
// Per-tile controller between the global buffers and the 4x4 systolic array.
//
// Sequence: IDLE -> FETCH (5 cycles, A and B rows) -> RUN (sa_busy high until
// sa_done or timeout) -> WB (4 C row writes) -> DONE (1-cycle done pulse).
// A timeout in RUN sets the sticky err flag and skips write-back.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start, base_A/B/C        : tile request and row base addresses (IDLE only)
//   A_addr/A_data            : global buffer A read port (1-cycle latency)
//   B_addr/B_data            : global buffer B read port (1-cycle latency)
//   C_wen/C_addr/C_data      : global buffer C write port
//   sa_busy/sa_done          : array handshake
//   sa_A0..3, sa_B0..3       : operand rows to the array
//   sa_C0..3                 : result rows from the array
//   ready, done, err         : idle flag, completion pulse, sticky timeout
module tile_dma_ctrl
  import tile_dma_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_BITS  = DefAddrBits,
  parameter int unsigned DATA_BITS  = DefDataBits,
  parameter int unsigned DATAC_BITS = DefDataCBits,
  parameter int unsigned TIMEOUT    = DefTimeout
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_BITS-1:0]  base_A,
  input  logic [ADDR_BITS-1:0]  base_B,
  input  logic [ADDR_BITS-1:0]  base_C,
  output logic [ADDR_BITS-1:0]  A_addr,
  input  logic [DATA_BITS-1:0]  A_data,
  output logic [ADDR_BITS-1:0]  B_addr,
  input  logic [DATA_BITS-1:0]  B_data,
  output logic                  C_wen,
  output logic [ADDR_BITS-1:0]  C_addr,
  output logic [DATAC_BITS-1:0] C_data,
  output logic                  sa_busy,
  input  logic                  sa_done,
  output logic [DATA_BITS-1:0]  sa_A0,
  output logic [DATA_BITS-1:0]  sa_A1,
  output logic [DATA_BITS-1:0]  sa_A2,
  output logic [DATA_BITS-1:0]  sa_A3,
  output logic [DATA_BITS-1:0]  sa_B0,
  output logic [DATA_BITS-1:0]  sa_B1,
  output logic [DATA_BITS-1:0]  sa_B2,
  output logic [DATA_BITS-1:0]  sa_B3,
  input  logic [DATAC_BITS-1:0] sa_C0,
  input  logic [DATAC_BITS-1:0] sa_C1,
  input  logic [DATAC_BITS-1:0] sa_C2,
  input  logic [DATAC_BITS-1:0] sa_C3,
  output logic                  ready,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned CntBits = $clog2(TIMEOUT + 1);

  state_e                          state_q, state_d;
  logic [IdxBits-1:0]              idx_q, idx_d;
  logic [CntBits-1:0]              cnt_q, cnt_d;
  logic                            err_q, err_d;
  logic [ADDR_BITS-1:0]            base_c_q, base_c_d;
  logic [Rows-1:0][DATAC_BITS-1:0] c_rows_q, c_rows_d;
  logic                            load;
  logic                            fetch;
  logic                            in_wb;
  logic [Rows-1:0][DATA_BITS-1:0]  a_rows, b_rows;

  assign fetch = (state_q == StFetch);
  assign in_wb = (state_q == StWb);

  tile_row_fetch #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_fetch_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .base    (base_A),
    .fetch   (fetch),
    .idx     (idx_q),
    .addr    (A_addr),
    .rd_data (A_data),
    .rows    (a_rows)
  );

  tile_row_fetch #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_fetch_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .base    (base_B),
    .fetch   (fetch),
    .idx     (idx_q),
    .addr    (B_addr),
    .rd_data (B_data),
    .rows    (b_rows)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    base_c_d = base_c_q;
    c_rows_d = c_rows_q;
    load     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          load     = 1'b1;
          err_d    = 1'b0;
          base_c_d = base_C;
          idx_d    = '0;
          state_d  = StFetch;
        end
      end
      StFetch: begin
        // Last operand row lands on the exit edge, so operands are stable
        // before the array first sees busy.
        if (idx_q == IdxBits'(Rows)) begin
          idx_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StRun: begin
        // Leaving RUN drops sa_busy on the same edge, so the array never sees
        // busy again once it has reported done.
        if (sa_done) begin
          c_rows_d[0] = sa_C0;
          c_rows_d[1] = sa_C1;
          c_rows_d[2] = sa_C2;
          c_rows_d[3] = sa_C3;
          idx_d       = '0;
          state_d     = StWb;
        end else if (cnt_q == CntBits'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWb: begin
        if (idx_q == IdxBits'(Rows - 1)) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      base_c_q <= '0;
      c_rows_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      base_c_q <= base_c_d;
      c_rows_q <= c_rows_d;
    end
  end

  // Outputs decode straight from state so an async reset kills any write at once.
  assign ready   = (state_q == StIdle);
  assign done    = (state_q == StDone);
  assign sa_busy = (state_q == StRun);
  assign err     = err_q;
  assign C_wen   = in_wb;
  assign C_addr  = in_wb ? (base_c_q + ADDR_BITS'(idx_q)) : '0;
  assign C_data  = in_wb ? c_rows_q[idx_q[RowBits-1:0]] : '0;

  assign sa_A0 = a_rows[0];
  assign sa_A1 = a_rows[1];
  assign sa_A2 = a_rows[2];
  assign sa_A3 = a_rows[3];
  assign sa_B0 = b_rows[0];
  assign sa_B1 = b_rows[1];
  assign sa_B2 = b_rows[2];
  assign sa_B3 = b_rows[3];

endmodule

// File: tb/tb_tile_dma_ctrl.sv
// Directed bench for tile_dma_ctrl with buffer memories and an array model.
module tb_tile_dma_ctrl;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [15:0]  base_A, base_B, base_C, A_addr, B_addr, C_addr;
  logic [31:0]  A_data, B_data;
  logic         C_wen, sa_busy, sa_done, ready, done, err;
  logic [127:0] C_data, sa_C0, sa_C1, sa_C2, sa_C3;
  logic [31:0]  sa_A0, sa_A1, sa_A2, sa_A3, sa_B0, sa_B1, sa_B2, sa_B3;

  int tests = 0;
  int fails = 0;
  int n;
  int mode;       // 0: computing array, 1: stub done after 3 busy cycles, 2: never done
  int busy_cyc;
  int busy_total;
  int done_cnt;

  logic [31:0]  mem_a [65536];
  logic [31:0]  mem_b [65536];
  logic [15:0]  cw_addr [$];
  logic [127:0] cw_data [$];
  logic [127:0] exp_c [4];
  logic [127:0] stub_c [4];

  always #5 clk = ~clk;

  tile_dma_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .base_A  (base_A),
    .base_B  (base_B),
    .base_C  (base_C),
    .A_addr  (A_addr),
    .A_data  (A_data),
    .B_addr  (B_addr),
    .B_data  (B_data),
    .C_wen   (C_wen),
    .C_addr  (C_addr),
    .C_data  (C_data),
    .sa_busy (sa_busy),
    .sa_done (sa_done),
    .sa_A0   (sa_A0),
    .sa_A1   (sa_A1),
    .sa_A2   (sa_A2),
    .sa_A3   (sa_A3),
    .sa_B0   (sa_B0),
    .sa_B1   (sa_B1),
    .sa_B2   (sa_B2),
    .sa_B3   (sa_B3),
    .sa_C0   (sa_C0),
    .sa_C1   (sa_C1),
    .sa_C2   (sa_C2),
    .sa_C3   (sa_C3),
    .ready   (ready),
    .done    (done),
    .err     (err)
  );

  // Synchronous-read global buffers.
  always @(posedge clk) begin
    A_data <= mem_a[A_addr];
    B_data <= mem_b[B_addr];
  end

  // One C row: int8 row a times the 4x4 int8 matrix b (rows MSB first).
  function automatic logic [127:0] mm_row(input logic [31:0] a, input logic [127:0] b);
    logic [127:0]      r;
    int                acc;
    logic signed [7:0] ea, eb;
    r = '0;
    for (int j = 0; j < 4; j++) begin
      acc = 0;
      for (int k = 0; k < 4; k++) begin
        ea  = a[31-8*k -: 8];
        eb  = b[127-32*k-8*j -: 8];
        acc = acc + int'(ea) * int'(eb);
      end
      r[127-32*j -: 32] = acc;
    end
    return r;
  endfunction

  // Array model, updated 1 time unit after each rising edge.
  always begin
    @(posedge clk);
    #1;
    sa_done = 1'b0;
    if (sa_busy) begin
      busy_cyc = busy_cyc + 1;
      if (mode == 0 && busy_cyc == 9) begin
        sa_C0   = mm_row(sa_A0, {sa_B0, sa_B1, sa_B2, sa_B3});
        sa_C1   = mm_row(sa_A1, {sa_B0, sa_B1, sa_B2, sa_B3});
        sa_C2   = mm_row(sa_A2, {sa_B0, sa_B1, sa_B2, sa_B3});
        sa_C3   = mm_row(sa_A3, {sa_B0, sa_B1, sa_B2, sa_B3});
        sa_done = 1'b1;
      end
      if (mode == 1 && busy_cyc == 3) begin
        sa_C0   = stub_c[0];
        sa_C1   = stub_c[1];
        sa_C2   = stub_c[2];
        sa_C3   = stub_c[3];
        sa_done = 1'b1;
      end
    end else begin
      busy_cyc = 0;
    end
  end

  // Observers on the falling edge.
  always @(negedge clk) begin
    if (C_wen) begin
      cw_addr.push_back(C_addr);
      cw_data.push_back(C_data);
    end
    if (done) done_cnt = done_cnt + 1;
    if (sa_busy) busy_total = busy_total + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    cw_addr.delete();
    cw_data.delete();
    done_cnt   = 0;
    busy_total = 0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    base_A = '0; base_B = '0; base_C = '0;
    mode = 0; busy_cyc = 0; busy_total = 0; done_cnt = 0;
    sa_done = 1'b0; sa_C0 = '0; sa_C1 = '0; sa_C2 = '0; sa_C3 = '0;
    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    mem_a[16'h0010] = 32'h01020304;
    mem_a[16'h0011] = 32'h05060708;
    mem_a[16'h0012] = 32'h090A0B0C;
    mem_a[16'h0013] = 32'h0D0E0F10;
    mem_b[16'h0020] = 32'h01000000;
    mem_b[16'h0021] = 32'h00010000;
    mem_b[16'h0022] = 32'h00000100;
    mem_b[16'h0023] = 32'h00000001;
    mem_a[16'hFFFE] = 32'h11111111;
    mem_a[16'hFFFF] = 32'h22222222;
    mem_a[16'h0000] = 32'h33333333;
    mem_a[16'h0001] = 32'h44444444;
    exp_c[0] = 128'h00000001_00000002_00000003_00000004;
    exp_c[1] = 128'h00000005_00000006_00000007_00000008;
    exp_c[2] = 128'h00000009_0000000A_0000000B_0000000C;
    exp_c[3] = 128'h0000000D_0000000E_0000000F_00000010;
    stub_c[0] = {4{32'hAAAAAAAA}};
    stub_c[1] = {4{32'hBBBBBBBB}};
    stub_c[2] = {4{32'hCCCCCCCC}};
    stub_c[3] = {4{32'hDDDDDDDD}};

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", ready, 1);
    check("rst_busy", sa_busy, 0);
    check("rst_wen_done_err", {C_wen, done, err}, 0);
    check("rst_addrs", {A_addr, B_addr, C_addr}, 0);
    check("rst_cdata", C_data, 0);
    check("rst_sa_rows", {sa_A0, sa_A1, sa_A2, sa_A3, sa_B0, sa_B1, sa_B2, sa_B3}, 0);
    rst_n = 1'b1;
    tick();

    // 1: reset in the middle of RUN.
    mode = 2; base_A = 16'h0010; base_B = 16'h0020; base_C = 16'h0040;
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!sa_busy && n < 20) begin tick(); n++; end
    check("t1_busy_seen", sa_busy, 1);
    check("t1_rows_loaded", {sa_A0, sa_A3, sa_B0, sa_B3},
          {32'h01020304, 32'h0D0E0F10, 32'h01000000, 32'h00000001});
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    check("t1_rst_busy", sa_busy, 0);
    check("t1_rst_ready", ready, 1);
    check("t1_rst_wen", C_wen, 0);
    check("t1_rst_rows", {sa_A0, sa_A1, sa_A2, sa_A3, sa_B0, sa_B1, sa_B2, sa_B3}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check("t1_no_cwrites", cw_addr.size(), 0);

    // 2: A times identity through the computing array model.
    mode = 0;
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    n = 1;
    while (!done && n < 200) begin tick(); n++; end
    check("t2_done_seen", done, 1);
    check("t2_latency", n, 19);
    tick();
    check("t2_cw_count", cw_addr.size(), 4);
    for (int r = 0; r < 4; r++) begin
      if (cw_addr.size() > r) begin
        check($sformatf("t2_c_addr%0d", r), cw_addr[r], 16'h0040 + 16'(r));
        check($sformatf("t2_c_data%0d", r), cw_data[r], exp_c[r]);
      end
    end
    check("t2_ready_after", ready, 1);
    check("t2_done_pulses", done_cnt, 1);

    // 3: stub array, busy must drop on the edge that samples sa_done.
    mode = 1; base_C = 16'h0080;
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!sa_done && n < 40) begin tick(); n++; end
    check("t3_sa_done_seen", sa_done, 1);
    check("t3_busy_before", sa_busy, 1);
    tick();
    check("t3_busy_dropped", sa_busy, 0);
    check("t3_wen_first", {C_wen, C_addr}, {1'b1, 16'h0080});
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check("t3_done_seen", done, 1);
    check("t3_cw_count", cw_addr.size(), 4);
    for (int r = 0; r < 4; r++) begin
      if (cw_data.size() > r) begin
        check($sformatf("t3_c_data%0d", r), cw_data[r], stub_c[r]);
      end
    end
    tick();

    // 4: address wrap on A.
    base_A = 16'hFFFE; base_B = 16'h0020; base_C = 16'h0090;
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    check("t4_addr0", {A_addr, B_addr}, {16'hFFFE, 16'h0020});
    tick();
    check("t4_addr1", A_addr, 16'hFFFF);
    tick();
    check("t4_addr2", A_addr, 16'h0000);
    tick();
    check("t4_addr3", {A_addr, B_addr}, {16'h0001, 16'h0023});
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check("t4_done_seen", done, 1);
    check("t4_a_rows", {sa_A0, sa_A1, sa_A2, sa_A3},
          {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    tick();

    // 5: RUN timeout.
    mode = 2;
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    check("t5_done_seen", done, 1);
    check("t5_err_set", err, 1);
    check("t5_busy_cycles", busy_total, 64);
    check("t5_no_cwrites", cw_addr.size(), 0);
    tick();
    check("t5_err_sticky", {err, ready}, 2'b11);
    check("t5_done_pulses", done_cnt, 1);
    mode = 1;
    start = 1'b1; tick(); start = 1'b0;
    check("t5_err_cleared", err, 0);
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    tick();

    // 6: start ignored outside IDLE; back-to-back tiles with start held.
    mode = 1;
    clear_logs();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!C_wen && n < 40) begin tick(); n++; end
    check("t6_wb_seen", C_wen, 1);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    tick(); tick(); tick();
    check("t6_one_done", done_cnt, 1);
    check("t6_idle_after", ready, 1);
    clear_logs();
    start = 1'b1;
    tick();
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    check("t6_b2b_done1", done, 1);
    tick();
    check("t6_b2b_idle", ready, 1);
    tick();
    check("t6_b2b_accept", ready, 0);
    start = 1'b0;
    n = 0;
    while (!done && n < 40) begin tick(); n++; end
    tick(); tick();
    check("t6_b2b_pulses", done_cnt, 2);
    check("t6_b2b_cwrites", cw_addr.size(), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
